// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - MIPS 2-read/1-write general-purpose register file
//
// Purpose: 2**a entries of n bits. Entry 0 is the constant-zero $zero register
// and has no storage. Both read ports are combinational; the write port is
// clocked. With bypass=1 a write presented this cycle forwards onto any read
// port that addresses the same entry.
//
// Ports:
//   clk_port        in   1  rising-edge clock
//   rst_port        in   1  asynchronous active-high reset, clears entries 1..
//   wr_en_port      in   1  write enable, sampled at the rising edge
//   wr_addr_port    in   a  write address
//   wr_data_port    in   n  write data
//   rd_addr_a_port  in   a  read address, port A (rs)
//   rd_data_a_port  out  n  read data, port A
//   rd_addr_b_port  in   a  read address, port B (rt)
//   rd_data_b_port  out  n  read data, port B

module reg_file_2r1w #(
  parameter int n      = 32,
  parameter int a      = 5,
  parameter bit bypass = 1'b1
) (
  input  logic         clk_port,
  input  logic         rst_port,
  input  logic         wr_en_port,
  input  logic [a-1:0] wr_addr_port,
  input  logic [n-1:0] wr_data_port,
  input  logic [a-1:0] rd_addr_a_port,
  output logic [n-1:0] rd_data_a_port,
  input  logic [a-1:0] rd_addr_b_port,
  output logic [n-1:0] rd_data_b_port
);

  localparam int depth = 2 ** a;

  // Storage starts at index 1: $zero is never materialised as flops.
  logic [n-1:0] mem_q [1:depth-1];
  logic [n-1:0] mem_d [1:depth-1];

  logic wr_hit_a;
  logic wr_hit_b;

  always_comb begin
    mem_d = mem_q;
    // Writes to address 0 are dropped here, which is what keeps $zero at zero.
    if (wr_en_port && (wr_addr_port != '0)) begin
      mem_d[wr_addr_port] = wr_data_port;
    end
  end

  // Reset wins over the clock, so a write presented while rst_port is high
  // is ignored and the first write lands on the first edge after release.
  always_ff @(posedge clk_port or posedge rst_port) begin
    if (rst_port) begin
      for (int i = 1; i < depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    wr_hit_a = bypass && wr_en_port && (wr_addr_port == rd_addr_a_port);
    wr_hit_b = bypass && wr_en_port && (wr_addr_port == rd_addr_b_port);
  end

  // Read mux priority: reset, then $zero, then the forwarded write, then storage.
  // The $zero check sits above the bypass so a write aimed at r0 never leaks.
  always_comb begin
    rd_data_a_port = '0;
    if (rst_port) begin
      rd_data_a_port = '0;
    end else if (rd_addr_a_port == '0) begin
      rd_data_a_port = '0;
    end else if (wr_hit_a) begin
      rd_data_a_port = wr_data_port;
    end else begin
      rd_data_a_port = mem_q[rd_addr_a_port];
    end
  end

  always_comb begin
    rd_data_b_port = '0;
    if (rst_port) begin
      rd_data_b_port = '0;
    end else if (rd_addr_b_port == '0) begin
      rd_data_b_port = '0;
    end else if (wr_hit_b) begin
      rd_data_b_port = wr_data_port;
    end else begin
      rd_data_b_port = mem_q[rd_addr_b_port];
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb/tb_reg_file_2r1w.sv - directed and model-checked bench for reg_file_2r1w

module tb_reg_file_2r1w;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_a;
  logic [4:0]  rd_b;
  logic [31:0] ra1, rb1;  // bypass=1 instance
  logic [31:0] ra0, rb0;  // bypass=0 instance

  int checks;
  int failures;

  reg_file_2r1w #(.n(32), .a(5), .bypass(1'b1)) dut_byp (
    .clk_port       (clk),
    .rst_port       (rst),
    .wr_en_port     (wr_en),
    .wr_addr_port   (wr_addr),
    .wr_data_port   (wr_data),
    .rd_addr_a_port (rd_a),
    .rd_data_a_port (ra1),
    .rd_addr_b_port (rd_b),
    .rd_data_b_port (rb1)
  );

  reg_file_2r1w #(.n(32), .a(5), .bypass(1'b0)) dut_nob (
    .clk_port       (clk),
    .rst_port       (rst),
    .wr_en_port     (wr_en),
    .wr_addr_port   (wr_addr),
    .wr_data_port   (wr_data),
    .rd_addr_a_port (rd_a),
    .rd_data_a_port (ra0),
    .rd_addr_b_port (rd_b),
    .rd_data_b_port (rb0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Returns 2 time units after a rising edge; inputs change there.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_a = 5'd5; rd_b = 5'd31;
    #1 rst = 1'b1;
    #2;
    checks++;
    if (ra1 !== 32'h0 || rb1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_read got a=%h b=%h want 0", ra1, rb1);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ra0 !== 32'h0 || rb0 !== 32'h0) begin
      failures++;
      $display("FAIL reset_state got a=%h b=%h want 0", ra0, rb0);
    end
  endtask

  task automatic test_reset_clear();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0; rd_a = 5'd5;
    #1;
    checks++;
    if (ra1 !== 32'hDEADBEEF || ra0 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL r5_written got %h/%h want deadbeef", ra1, ra0);
    end
    rst = 1'b1;  // mid-cycle, no edge involved
    #1;
    checks++;
    if (ra1 !== 32'h0 || ra0 !== 32'h0) begin
      failures++;
      $display("FAIL async_reset_read got %h/%h want 0", ra1, ra0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ra1 !== 32'h0 || ra0 !== 32'h0) begin
      failures++;
      $display("FAIL r5_cleared got %h/%h want 0", ra1, ra0);
    end
    tick();
    checks++;
    if (ra1 !== 32'h0 || ra0 !== 32'h0) begin
      failures++;
      $display("FAIL r5_cleared_after_edge got %h/%h want 0", ra1, ra0);
    end
    // A write presented during reset is ignored and must not forward either.
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77; rd_a = 5'd3;
    #1;
    checks++;
    if (ra1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_blocks_bypass got %h want 0", ra1);
    end
    tick();
    rst = 1'b0; wr_en = 1'b0;
    #1;
    checks++;
    if (ra1 !== 32'h0 || ra0 !== 32'h0) begin
      failures++;
      $display("FAIL reset_blocks_write got %h/%h want 0", ra1, ra0);
    end
  endtask

  task automatic test_write_readback();
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h12345678;
    tick();
    wr_addr = 5'd1; wr_data = 32'hA5A5A5A5;
    tick();
    wr_en = 1'b0; rd_a = 5'd31; rd_b = 5'd1;
    #1;
    checks++;
    if (ra1 !== 32'h12345678 || ra0 !== 32'h12345678) begin
      failures++;
      $display("FAIL readback_r31 got %h/%h want 12345678", ra1, ra0);
    end
    checks++;
    if (rb1 !== 32'hA5A5A5A5 || rb0 !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL readback_r1 got %h/%h want a5a5a5a5", rb1, rb0);
    end
  endtask

  task automatic test_zero();
    rd_a = 5'd0; rd_b = 5'd0;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    #1;
    checks++;
    if (ra1 !== 32'h0 || rb1 !== 32'h0 || ra0 !== 32'h0 || rb0 !== 32'h0) begin
      failures++;
      $display("FAIL zero_during_write got %h %h %h %h want 0", ra1, rb1, ra0, rb0);
    end
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (ra1 !== 32'h0 || rb1 !== 32'h0 || ra0 !== 32'h0 || rb0 !== 32'h0) begin
      failures++;
      $display("FAIL zero_after_write got %h %h %h %h want 0", ra1, rb1, ra0, rb0);
    end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11;
    tick();
    wr_data = 32'h22; rd_a = 5'd7; rd_b = 5'd7;
    #1;
    checks++;
    if (ra1 !== 32'h22 || rb1 !== 32'h22) begin
      failures++;
      $display("FAIL bypass_forward got a=%h b=%h want 22", ra1, rb1);
    end
    checks++;
    if (ra0 !== 32'h11 || rb0 !== 32'h11) begin
      failures++;
      $display("FAIL nobypass_old got a=%h b=%h want 11", ra0, rb0);
    end
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (ra1 !== 32'h22 || rb1 !== 32'h22 || ra0 !== 32'h22 || rb0 !== 32'h22) begin
      failures++;
      $display("FAIL r7_after_edge got %h %h %h %h want 22", ra1, rb1, ra0, rb0);
    end
  endtask

  task automatic test_enable();
    wr_en = 1'b0; wr_addr = 5'd9; wr_data = 32'h55; rd_a = 5'd9; rd_b = 5'd9;
    #1;
    checks++;
    if (ra1 !== 32'h0 || rb1 !== 32'h0) begin
      failures++;
      $display("FAIL disabled_no_bypass got a=%h b=%h want 0", ra1, rb1);
    end
    repeat (3) tick();
    checks++;
    if (ra1 !== 32'h0 || ra0 !== 32'h0) begin
      failures++;
      $display("FAIL r9_unchanged got %h/%h want 0", ra1, ra0);
    end
  endtask

  task automatic test_random();
    logic [31:0] model [32];
    logic [31:0] exp_a0, exp_b0, exp_a1, exp_b1;
    int          bad;
    bad = 0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    wr_en = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      rd_a    = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_b    = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      #1;
      exp_a0 = (rd_a == 5'd0) ? 32'h0 : model[rd_a];
      exp_b0 = (rd_b == 5'd0) ? 32'h0 : model[rd_b];
      exp_a1 = (rd_a != 5'd0 && wr_en && wr_addr == rd_a) ? wr_data : exp_a0;
      exp_b1 = (rd_b != 5'd0 && wr_en && wr_addr == rd_b) ? wr_data : exp_b0;
      checks++;
      if (ra1 !== exp_a1 || rb1 !== exp_b1 || ra0 !== exp_a0 || rb0 !== exp_b0) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL random cyc=%0d got %h %h %h %h want %h %h %h %h",
                   c, ra1, rb1, ra0, rb0, exp_a1, exp_b1, exp_a0, exp_b0);
      end
      tick();
      if (wr_en && wr_addr != 5'd0) model[wr_addr] = wr_data;
    end
    wr_en = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_reset_clear();
    test_write_readback();
    test_zero();
    test_bypass();
    test_enable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
